adc_scan_ctrl: RTL
==================

ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 17, number of scanned channels, indices 0..NUM_CH-1.
REQ-002 The block SHALL have parameter SETTLE_CYC, default 16, mux settle cycles before each conversion start.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 1024, max cycles from adc_start to adc_done.
REQ-004 SYS_CLK  in  1  sole clock; all state on rising edge.
REQ-005 SYS_RST_N  in  1  asynchronous, active-low reset.
REQ-006 scan_en  in  1  level; 1 = scan continuously, 0 = stop after current channel.
REQ-007 adc_chan  out  5  channel/mux select presented to ADC front end.
REQ-008 adc_start  out  1  one-cycle conversion start pulse.
REQ-009 adc_done  in  1  one-cycle conversion-complete pulse.
REQ-010 adc_result  in  10  conversion result, valid only when adc_done=1.
REQ-011 adc_vals  out  10*NUM_CH  packed results, channel n at bits [10n+9:10n], feeds register-file adc inputs.
REQ-012 adc_err  out  NUM_CH  sticky per-channel timeout flags.
REQ-013 err_clr  in  1  one-cycle pulse clearing all adc_err bits.
REQ-014 scan_done  out  1  one-cycle pulse after channel NUM_CH-1 is stored.

Function
REQ-015 FSM states SHALL be IDLE, SETTLE, START, WAIT, STORE.
REQ-016 IDLE: scan_en=1 SHALL move to SETTLE next cycle; scan_en=0 SHALL hold IDLE.
REQ-017 SETTLE SHALL last exactly SETTLE_CYC cycles with adc_chan stable, then go to START.
REQ-018 START SHALL assert adc_start for exactly one cycle, clear the timeout counter, go to WAIT.
REQ-019 WAIT SHALL capture adc_result in the cycle adc_done=1 and go to STORE.
REQ-020 WAIT SHALL, if TIMEOUT_CYC cycles elapse without adc_done, set adc_err[chan], leave adc_vals[chan] unchanged, go to STORE.
REQ-021 adc_done coinciding with the timeout-expiry cycle SHALL count as success (done wins).
REQ-022 adc_done outside WAIT SHALL be ignored.
REQ-023 STORE SHALL write the captured value to adc_vals[chan] (success only) in one cycle and advance chan; chan NUM_CH-1 SHALL wrap to 0 and pulse scan_done that same cycle.
REQ-024 After STORE: scan_en=1 -> SETTLE; scan_en=0 -> IDLE; deasserting scan_en mid-channel SHALL never abort a started conversion.
REQ-025 Re-enabling from IDLE SHALL resume at the stored next channel, not channel 0.
REQ-026 err_clr coinciding with a new timeout SHALL leave that channel's bit set (set wins); other bits clear.
REQ-027 Per-channel latency without averaging SHALL be SETTLE_CYC + 1 (START) + wait + 1 (STORE) cycles.

Reset
REQ-028 Reset SHALL force IDLE, chan=0, adc_chan=0, adc_start=0, scan_done=0, adc_vals=0, adc_err=0, counters=0.
REQ-029 Reset asserted mid-conversion SHALL abandon it; a subsequently arriving adc_done SHALL be ignored.

Configuration
REQ-030 Macro ADC_SCAN_AVG_EN defined: each channel SHALL convert twice (START/WAIT repeated, no second SETTLE) and store (s0+s1)>>1 using an 11-bit sum, floored.
REQ-031 ADC_SCAN_AVG_EN averaging: a timeout on either sample SHALL set adc_err and skip the store.
REQ-032 ADC_SCAN_AVG_EN undefined: single conversion per channel, stored directly.

Verification
REQ-033 SETTLE_CYC=4, scan_en=1, ADC model returns 10'h100+chan 3 cycles after start -> adc_vals[n]=0x100+n for all 17, scan_done pulse after channel 16, adc_chan wraps to 0.
REQ-034 Model never answers channel 5, TIMEOUT_CYC=32 -> adc_err[5]=1 exactly 32 cycles after its adc_start, adc_vals[5] keeps previous value, scan proceeds to 6.
REQ-035 scan_en dropped during WAIT on channel 9 -> channel 9 stored, FSM IDLE; re-enable -> next adc_chan=10.
REQ-036 adc_done on timeout-expiry cycle with result 0x2AA -> stored 0x2AA, adc_err bit clear; err_clr same cycle as channel 3 timeout -> only adc_err[3] set.
REQ-037 SYS_RST_N low during WAIT, then adc_done pulse -> all outputs zero, state IDLE, pulse ignored.
REQ-038 ADC_SCAN_AVG_EN defined, samples 0x3FF and 0x000 -> stored 0x1FF; two adc_start pulses per channel.

Source files
------------

// File: rtl/adc_scan_ctrl.sv
// Round-robin ADC channel scanner: settle, start, wait (with timeout), store per channel.
// Optional build macro ADC_SCAN_AVG_EN converts each channel twice and stores the floored mean.
`timescale 1ns/1ps

module adc_scan_ctrl #(
  parameter int NUM_CH      = 17,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 SYS_CLK,
  input  logic                 SYS_RST_N,
  input  logic                 scan_en,
  output logic [4:0]           adc_chan,
  output logic                 adc_start,
  input  logic                 adc_done,
  input  logic [9:0]           adc_result,
  output logic [10*NUM_CH-1:0] adc_vals,
  output logic [NUM_CH-1:0]    adc_err,
  input  logic                 err_clr,
  output logic                 scan_done
);

  typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT, STORE} state_e;

  localparam int SCW = $clog2(SETTLE_CYC + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC - 1);
  // The START cycle is the first of the TIMEOUT_CYC cycles, so the error flag
  // rises exactly TIMEOUT_CYC clocks after adc_start.
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYC - 2);
  localparam logic [4:0] CH_LAST = 5'(NUM_CH - 1);

  state_e                state_q, state_d;
  logic [4:0]            chan_q, chan_d;
  logic [SCW-1:0]        settle_cnt_q, settle_cnt_d;
  logic [TCW-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic [9:0]            res_q, res_d;
  logic                  ok_q, ok_d;
  logic [10*NUM_CH-1:0]  vals_q, vals_d;
  logic [NUM_CH-1:0]     err_q, err_d;
  logic                  scan_done_q, scan_done_d;
  logic                  err_set;
  int                    ch_idx;
`ifdef ADC_SCAN_AVG_EN
  logic                  samp_q, samp_d;
  logic [9:0]            s0_q, s0_d;
  logic [10:0]           avg_sum;
`endif

  assign ch_idx = int'(chan_q);

  // NOTE: the result bank is ordinary flops, not a RAM, and its zero value is
  // visible on adc_vals after reset, so it is reset along with the control state.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      state_q      <= IDLE;
      chan_q       <= '0;
      settle_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      res_q        <= '0;
      ok_q         <= 1'b0;
      vals_q       <= '0;
      err_q        <= '0;
      scan_done_q  <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
      samp_q       <= 1'b0;
      s0_q         <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q      <= state_d;
      chan_q       <= chan_d;
      settle_cnt_q <= settle_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      res_q        <= res_d;
      ok_q         <= ok_d;
      vals_q       <= vals_d;
      err_q        <= err_d;
      scan_done_q  <= scan_done_d;
`ifdef ADC_SCAN_AVG_EN
      samp_q       <= samp_d;
      s0_q         <= s0_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d      = state_q;
    chan_d       = chan_q;
    settle_cnt_d = settle_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    res_d        = res_q;
    ok_d         = ok_q;
    vals_d       = vals_q;
    scan_done_d  = 1'b0;
    err_set      = 1'b0;
`ifdef ADC_SCAN_AVG_EN
    samp_d       = samp_q;
    s0_d         = s0_q;
    avg_sum      = {1'b0, s0_q} + {1'b0, adc_result};
`endif

    case (state_q)
      IDLE: begin
        if (scan_en) begin
          state_d      = SETTLE;
          settle_cnt_d = '0;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) state_d = START;
        else settle_cnt_d = settle_cnt_q + SCW'(1);
      end
      START: begin
        tmo_cnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        // adc_done is tested first so a response in the expiry cycle still counts.
        if (adc_done) begin
`ifdef ADC_SCAN_AVG_EN
          if (!samp_q) begin
            s0_d    = adc_result;
            samp_d  = 1'b1;
            state_d = START;
          end else begin
            res_d   = avg_sum[10:1];
            ok_d    = 1'b1;
            state_d = STORE;
          end
`else
          res_d   = adc_result;
          ok_d    = 1'b1;
          state_d = STORE;
`endif
        end else if (tmo_cnt_q == TMO_LAST) begin
          err_set = 1'b1;
          ok_d    = 1'b0;
          state_d = STORE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TCW'(1);
        end
      end
      STORE: begin
        if (ok_q) vals_d[ch_idx*10 +: 10] = res_q;
        if (chan_q == CH_LAST) begin
          chan_d      = '0;
          scan_done_d = 1'b1;
        end else begin
          chan_d = chan_q + 5'd1;
        end
`ifdef ADC_SCAN_AVG_EN
        samp_d = 1'b0;
`endif
        settle_cnt_d = '0;
        state_d      = scan_en ? SETTLE : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A timeout landing with err_clr keeps its own bit.
    err_d = err_clr ? '0 : err_q;
    if (err_set) err_d[ch_idx] = 1'b1;
  end

  assign adc_chan  = chan_q;
  assign adc_start = (state_q == START);
  assign adc_vals  = vals_q;
  assign adc_err   = err_q;
  assign scan_done = scan_done_q;

endmodule
